wwm_btn_conditioner: RTL and testbench

Per-button input conditioner for World War Math: synchronizes, debounces and edge-detects the raw Nexys4 push-buttons before they reach the game state machine. It sits between the button pads (BtnU = Start, BtnR = Fire) and wwm_sm. For each button it provides:
- a clean level;
- a single-cycle press pulse (SCEN), which replaces raw Start/Fire;
- an auto-repeat pulse (MCEN), for future held-button controls such as power/angle stepping.

---
 rtl/wwm_btn_conditioner_if.sv | 29 ++
 rtl/wwm_btn_conditioner.sv | 140 ++++++++++++++
 tb/tb_wwm_btn_conditioner.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wwm_btn_conditioner_if.sv
// wwm_btn_conditioner_if
// Groups the per-button signals between the button pads and the conditioner.
//   btn_raw  : raw, asynchronous, bouncing levels from the pads (1 = pressed)
//   btn_db   : debounced level
//   btn_scen : one-cycle pulse per accepted press
//   btn_mcen : one-cycle pulse on press, then auto-repeat while held
// Modports: master = pad/consumer side, slave = conditioner.
interface wwm_btn_conditioner_if #(
  parameter int unsigned N_BTN = 2
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_db;
  logic [N_BTN-1:0] btn_scen;
  logic [N_BTN-1:0] btn_mcen;

  modport master (
    output btn_raw,
    input  btn_db,
    input  btn_scen,
    input  btn_mcen
  );

  modport slave (
    input  btn_raw,
    output btn_db,
    output btn_scen,
    output btn_mcen
  );
endinterface

// File: rtl/wwm_btn_conditioner.sv
// wwm_btn_conditioner
// Per-button conditioner for World War Math: 2-flop synchronizer, debounce,
// single press pulse (SCEN) and auto-repeat pulse (MCEN) for each channel.
// Channels are fully independent and share no state.
// Ports:
//   board_clk : system clock (100 MHz)
//   Reset     : asynchronous, active-high reset
//   io_btn    : slave modport carrying btn_raw in, btn_db/btn_scen/btn_mcen out
module wwm_btn_conditioner #(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 2_500_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000,
  parameter int unsigned CNT_W           = 27
) (
  input logic                  board_clk,
  input logic                  Reset,
  wwm_btn_conditioner_if.slave io_btn
);

  typedef enum logic [2:0] {
    StIni,
    StWq,
    StScen,
    StHold,
    StMcen,
    StWfcr
  } state_e;

  // Terminal counts (count - 1) for the equality compares.
  localparam logic [CNT_W-1:0] DbLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DlyLast = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PerLast = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [N_BTN-1:0] w_db;
  logic [N_BTN-1:0] w_scen;
  logic [N_BTN-1:0] w_mcen;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    logic             r_sync1;
    logic             r_sync2;
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_first;  // HOLD is timing the first repeat (REPEAT_DELAY)
    logic             r_db;
    logic             r_scen;
    logic             r_mcen;
    logic [CNT_W-1:0] w_hold_last;

    assign w_hold_last = r_first ? DlyLast : PerLast;

    // Outputs are registered alongside the state so they are glitch-free.
    always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_state <= StIni;
        r_cnt   <= '0;
        r_first <= 1'b0;
        r_db    <= 1'b0;
        r_scen  <= 1'b0;
        r_mcen  <= 1'b0;
      end else begin
        r_sync1 <= io_btn.btn_raw[g];
        r_sync2 <= r_sync1;
        r_scen  <= 1'b0;
        r_mcen  <= 1'b0;
        case (r_state)
          StIni: begin
            r_cnt <= '0;
            if (r_sync2) begin
              r_state <= StWq;
            end
          end
          StWq: begin
            if (!r_sync2) begin
              r_state <= StIni;
              r_cnt   <= '0;
            end else if (r_cnt == DbLast) begin
              r_state <= StScen;
              r_scen  <= 1'b1;
              r_mcen  <= 1'b1;
              r_db    <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CntOne;
            end
          end
          StScen: begin
            r_state <= StHold;
            r_cnt   <= '0;
            r_first <= 1'b1;
          end
          StHold: begin
            if (!r_sync2) begin
              r_state <= StWfcr;
              r_cnt   <= '0;
            end else if (r_cnt == w_hold_last) begin
              r_state <= StMcen;
              r_mcen  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CntOne;
            end
          end
          StMcen: begin
            // A release seen here is picked up by HOLD on the next cycle.
            r_state <= StHold;
            r_cnt   <= '0;
            r_first <= 1'b0;
          end
          StWfcr: begin
            if (r_sync2) begin
              r_cnt <= '0;  // bounce: restart release qualification
            end else if (r_cnt == DbLast) begin
              r_state <= StIni;
              r_cnt   <= '0;
              r_db    <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CntOne;
            end
          end
          default: begin
            r_state <= StIni;
            r_cnt   <= '0;
            r_db    <= 1'b0;
          end
        endcase
      end
    end

    assign w_db[g]   = r_db;
    assign w_scen[g] = r_scen;
    assign w_mcen[g] = r_mcen;
  end

  assign io_btn.btn_db   = w_db;
  assign io_btn.btn_scen = w_scen;
  assign io_btn.btn_mcen = w_mcen;

endmodule

// File: tb/tb_wwm_btn_conditioner.sv
// tb_wwm_btn_conditioner
// Directed bench for wwm_btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=3. Each step drives btn_raw, pushes the expected outputs after
// the next rising edge, then pops and compares 1 ns after that edge.
module tb_wwm_btn_conditioner;

  logic board_clk = 1'b0;
  logic Reset     = 1'b1;

  always #5 board_clk = ~board_clk;

  wwm_btn_conditioner_if #(.N_BTN(2)) bif ();

  wwm_btn_conditioner #(
    .N_BTN          (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3),
    .CNT_W          (4)
  ) dut (
    .board_clk(board_clk),
    .Reset    (Reset),
    .io_btn   (bif)
  );

  logic [5:0] exp_q[$];  // {db[1:0], scen[1:0], mcen[1:0]}
  int n_vec = 0;
  int n_err = 0;

  task automatic compare(input string tag);
    logic [5:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      assert (bif.btn_db === e[5:4]) else begin
        n_err++;
        $error("FAIL %s btn_db: got %b want %b", tag, bif.btn_db, e[5:4]);
      end
      assert (bif.btn_scen === e[3:2]) else begin
        n_err++;
        $error("FAIL %s btn_scen: got %b want %b", tag, bif.btn_scen, e[3:2]);
      end
      assert (bif.btn_mcen === e[1:0]) else begin
        n_err++;
        $error("FAIL %s btn_mcen: got %b want %b", tag, bif.btn_mcen, e[1:0]);
      end
    end
  endtask

  // Drive raw, advance one edge, check outputs as they stand after that edge.
  task automatic step(input logic [1:0] raw, input logic [1:0] edb, input logic [1:0] escen,
                      input logic [1:0] emcen, input string tag);
    exp_q.push_back({edb, escen, emcen});
    bif.btn_raw = raw;
    @(posedge board_clk);
    #1;
    compare(tag);
  endtask

  // Check for all-zero outputs right now, without waiting for an edge.
  task automatic check_zero_now(input string tag);
    exp_q.push_back(6'b0);
    compare(tag);
  endtask

  initial begin
    bif.btn_raw = 2'b00;
    Reset = 1'b1;
    repeat (2) @(posedge board_clk);
    #1;
    check_zero_now("reset_hold");
    Reset = 1'b0;
    for (int e = 1; e <= 3; e++) step(2'b00, 2'b00, 2'b00, 2'b00, "idle");

    // Clean press on channel 0 held 12 edges; channel 1 stays quiet.
    for (int e = 1; e <= 12; e++)
      step(2'b01, {1'b0, e >= 7}, {1'b0, e == 7}, {1'b0, e == 7}, "clean_press");
    for (int e = 1; e <= 10; e++)
      step(2'b00, {1'b0, e < 7}, 2'b00, 2'b00, "clean_release");

    // Burst 1,1,1,0 then held: the 0 on edge 4 restarts; final rise is edge 5, SCEN on 5+6.
    for (int e = 1; e <= 16; e++)
      step((e == 4) ? 2'b00 : 2'b01, {1'b0, e >= 11}, {1'b0, e == 11}, {1'b0, e == 11},
           "bounce_press");
    for (int e = 1; e <= 10; e++)
      step(2'b00, {1'b0, e < 7}, 2'b00, 2'b00, "bounce_press_release");

    // Long hold: MCEN at 7, then +9, then every +4.
    for (int e = 1; e <= 30; e++)
      step(2'b01, {1'b0, e >= 7}, {1'b0, e == 7}, {1'b0, (e inside {7, 16, 20, 24, 28})},
           "hold30");
    // Samples 29/30 are still 1 when the FSM reaches edge 32, so one more repeat lands
    // there; the MCEN cycle delays WFCR entry by one, so db falls on release edge 8.
    for (int e = 1; e <= 10; e++)
      step(2'b00, {1'b0, e < 8}, 2'b00, {1'b0, e == 2}, "hold30_release");

    // Press, then release bouncing 0,0,1,0. The bounce is seen in WFCR with the counter
    // already cleared, so db falls five edges after the last falling sample (step 4).
    for (int e = 1; e <= 10; e++)
      step(2'b01, {1'b0, e >= 7}, {1'b0, e == 7}, {1'b0, e == 7}, "press_for_bounce_rel");
    for (int e = 1; e <= 12; e++)
      step((e == 3) ? 2'b01 : 2'b00, {1'b0, e < 9}, 2'b00, 2'b00, "bounce_release");

    // Reset while in WQ (counter 2) with the button held, then re-qualify from INI.
    for (int e = 1; e <= 5; e++) step(2'b01, 2'b00, 2'b00, 2'b00, "press_to_wq");
    Reset = 1'b1;
    #1;
    check_zero_now("reset_in_wq");
    for (int e = 1; e <= 2; e++) step(2'b01, 2'b00, 2'b00, 2'b00, "reset_held");
    Reset = 1'b0;
    for (int e = 1; e <= 10; e++)
      step(2'b01, {1'b0, e >= 7}, {1'b0, e == 7}, {1'b0, e == 7}, "post_reset_press");
    for (int e = 1; e <= 10; e++)
      step(2'b00, {1'b0, e < 7}, 2'b00, 2'b00, "post_reset_release");

    // Both channels pressed on the same edge.
    for (int e = 1; e <= 9; e++)
      step(2'b11, {2{e >= 7}}, {2{e == 7}}, {2{e == 7}}, "dual_press");
    // Asynchronous reset with db high must clear outputs without a clock edge.
    Reset = 1'b1;
    bif.btn_raw = 2'b00;
    #1;
    check_zero_now("async_reset_db");
    step(2'b00, 2'b00, 2'b00, 2'b00, "async_reset_held");
    Reset = 1'b0;
    for (int e = 1; e <= 3; e++) step(2'b00, 2'b00, 2'b00, 2'b00, "final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
